// File: rtl/bch_arb_pkg.sv
// rtl/bch_arb_pkg.sv - shared state encoding, source tag type and BCH generator lookup
package bch_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int SRC_W = 1;
  typedef logic [SRC_W-1:0] src_t;

  // Generator polynomials (MSB = x^(N-K)) for the supported length-15 codes.
  function automatic logic [31:0] bch_gen_poly(input int n, input int k, input int t);
    if (n == 15 && k == 5 && t == 3)       return 32'h0000_0537;
    else if (n == 15 && k == 7 && t == 2)  return 32'h0000_01D1;
    else if (n == 15 && k == 11 && t == 1) return 32'h0000_0013;
    else                                   return 32'h0000_0000;
  endfunction

endpackage

// File: rtl/bch_encode.sv
// rtl/bch_encode.sv - bit-serial systematic BCH encoder, message bits then parity, MSB first
module bch_encode
  import bch_arb_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 5,
  parameter int T = 3
) (
  input  logic clk,
  input  logic start,
  input  logic data_in,
  output logic data_out,
  output logic first,
  output logic last
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N);
  localparam logic [R:0] G = (R+1)'(bch_gen_poly(N, K, T));

  logic [R-1:0]  r_lfsr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [CW-1:0] w_nxt;

  function automatic logic [R-1:0] lfsr_step(input logic [R-1:0] s, input logic b);
    logic fb;
    fb = b ^ s[R-1];
    return {s[R-2:0], 1'b0} ^ (fb ? G[R-1:0] : '0);
  endfunction

  assign w_nxt = r_cnt + CW'(1);

  // No reset: a start pulse fully re-initialises the divider and counters.
  always_ff @(posedge clk) begin
    first <= 1'b0;
    last  <= 1'b0;
    if (start) begin
      r_lfsr   <= lfsr_step('0, data_in);
      data_out <= data_in;
      first    <= 1'b1;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= w_nxt;
      if (w_nxt < CW'(K)) begin
        data_out <= data_in;
        r_lfsr   <= lfsr_step(r_lfsr, data_in);
      end else begin
        data_out <= r_lfsr[R-1];
        r_lfsr   <= {r_lfsr[R-2:0], 1'b0};
      end
      if (w_nxt == CW'(N-1)) begin
        last   <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bch_encode_arb.sv
// rtl/bch_encode_arb.sv - round-robin two-source front end sequencing frames through one serial BCH encoder
module bch_encode_arb
  import bch_arb_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 5,
  parameter int T = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [K-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [K-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output src_t         out_src,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  arb_state_t    r_state, w_state_nxt;
  logic [K-1:0]  r_msg;
  src_t          r_tag;
  logic          r_rr;
  logic [CW-1:0] r_cnt;
  logic [N-2:0]  r_coll;
  logic          r_coll_en;

  logic w_can_grant, w_pick1, w_grant, w_active, w_load;
  logic w_start, w_din, w_enc_dout, w_enc_first, w_enc_last;

  bch_encode #(.N(N), .K(K), .T(T)) u_enc (
    .clk      (clk),
    .start    (w_start),
    .data_in  (w_din),
    .data_out (w_enc_dout),
    .first    (w_enc_first),
    .last     (w_enc_last)
  );

  always_comb begin
    w_can_grant = (r_state == ST_IDLE) && (!out_valid || out_ready);
    w_pick1     = req1_valid && (!req0_valid || r_rr);
    req0_ready  = w_can_grant && req0_valid && !w_pick1;
    req1_ready  = w_can_grant && w_pick1;
    w_grant     = req0_ready || req1_ready;
    w_active    = (r_state != ST_IDLE);
    w_start     = (r_state == ST_FEED) && (r_cnt == '0);
    w_din       = (r_state == ST_FEED) ? r_msg[K-1] : 1'b0;
    // Encoder flags are trusted only in DRAIN, so a stale frame cannot load.
    w_load      = (r_state == ST_DRAIN) && w_enc_last;
    busy        = w_active;

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_FEED;
      ST_FEED:  if (r_cnt == CW'(K-1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_enc_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_msg     <= '0;
      r_tag     <= '0;
      r_rr      <= 1'b0;
      r_cnt     <= '0;
      r_coll    <= '0;
      r_coll_en <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant) begin
        r_msg <= req1_ready ? req1_data : req0_data;
        r_tag <= req1_ready;
        r_rr  <= req0_ready;
        r_cnt <= '0;
      end else if (r_state == ST_FEED) begin
        r_msg <= {r_msg[K-2:0], 1'b0};
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_active && (w_enc_first || r_coll_en))
        r_coll <= {r_coll[N-3:0], w_enc_dout};
      r_coll_en <= w_active && !w_load && (r_coll_en || w_enc_first);

      if (w_load) begin
        out_data  <= {r_coll, w_enc_dout};
        out_src   <= r_tag;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_encode_arb.sv
// tb/tb_bch_encode_arb.sv - directed and randomised self-checking bench for bch_encode_arb
module tb_bch_encode_arb;
  localparam int N = 15;
  localparam int K = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [K-1:0] req0_data, req1_data;
  logic         out_valid, out_ready, busy;
  logic [N-1:0] out_data;
  logic [0:0]   out_src;

  bch_encode_arb #(.N(N), .K(K), .T(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] ref_cw(input logic [K-1:0] m);
    logic [N-1:0] r;
    r = {m, 10'b0};
    for (int i = N-1; i >= N-K; i--)
      if (r[i]) r = r ^ (15'h0537 << (i - (N-K)));
    return {m, r[N-K-1:0]};
  endfunction

  typedef struct { logic src; logic [N-1:0] cw; int cyc; } exp_t;
  exp_t q[$];
  logic g_src[$];
  int   g_cyc[$];
  int   cyc = 0;
  int   n_acc = 0;
  int   n_valid_cyc = 0;
  logic prev_v = 1'b0;
  logic [N-1:0] last_data;
  logic         last_src;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else check("latency", cyc - q[0].cyc, N + 2);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_accept", 32'd1, 32'd0);
        else begin
          check("cw_data", out_data, q[0].cw);
          check("cw_src", out_src, q[0].src);
          void'(q.pop_front());
        end
        last_data = out_data;
        last_src  = out_src[0];
        n_acc++;
      end
      if (req0_valid && req0_ready) begin
        q.push_back('{1'b0, ref_cw(req0_data), cyc});
        g_src.push_back(1'b0); g_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        q.push_back('{1'b1, ref_cw(req1_data), cyc});
        g_src.push_back(1'b1); g_cyc.push_back(cyc);
      end
      if (out_valid) n_valid_cyc++;
      prev_v = out_valid && !out_ready;
    end
    cyc++;
  end

  task automatic send(input int src, input logic [K-1:0] d);
    bit done;
    done = 0;
    @(posedge clk); #1;
    if (src == 0) begin req0_valid = 1; req0_data = d; end
    else          begin req1_valid = 1; req1_data = d; end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #2;
      done = (src == 0) ? req0_ready : req1_ready;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (src == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk); #2;
      done = (q.size() == 0) && !out_valid && !busy;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base, viol, gbase, abase;
    logic [N-1:0] held;
    bit hs0, hs1, seen;
    reset = 1; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 0;

    out_ready = 1; n_valid_cyc = 0;
    send(0, 5'b00001); wait_empty();
    check("t1_data", last_data, 15'h0537);
    check("t1_src", last_src, 0);
    check("t1_width", n_valid_cyc, 1);

    send(1, 5'b11111); wait_empty();
    check("t2_ones", last_data, 15'h7FFF);
    check("t2_src", last_src, 1);
    send(1, 5'b00000); wait_empty();
    check("t2_zero", last_data, 0);

    base = g_src.size();
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 5'h01; req1_valid = 1; req1_data = 5'h1F;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #2;
      seen = (g_src.size() >= base + 4);
    end
    if (!seen) check("rr_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    wait_empty();
    if (seen)
      for (int i = 0; i < 4; i++) begin
        check("rr_src", g_src[base+i], i % 2);
        if (i > 0) check("rr_gap", g_cyc[base+i] - g_cyc[base+i-1], N + 2);
      end

    out_ready = 0;
    send(0, 5'b00001);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); #2; seen = out_valid; end
    check("hold_seen", seen, 1);
    held = out_data;
    @(posedge clk); #1 req1_valid = 1; req1_data = 5'h1F;
    viol = 0;
    repeat (40) begin
      @(negedge clk); #2;
      if (out_data !== held || req0_ready || req1_ready || busy || !out_valid) viol++;
    end
    check("hold_viol", viol, 0);
    check("hold_data", held, 15'h0537);
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk); #2;
    check("rel_grant", req1_ready, 1);
    check("rel_valid", out_valid, 1);
    @(posedge clk); #1 req1_valid = 0;
    wait_empty();
    check("rel_next", last_data, 15'h7FFF);

    send(0, 5'b00001);
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    n_valid_cyc = 0;
    repeat (30) @(negedge clk);
    #2;
    check("mid_no_valid", n_valid_cyc, 0);
    send(0, 5'b00001); wait_empty();
    check("mid_after", last_data, 15'h0537);

    gbase = g_src.size(); abase = n_acc; hs0 = 0; hs1 = 0;
    for (int i = 0; i < 3000 && g_src.size() < gbase + 24; i++) begin
      @(posedge clk); #1;
      if (hs0) req0_valid = 0;
      if (hs1) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1; req0_data = K'($urandom_range(0, 31));
      end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1; req1_data = K'($urandom_range(0, 31));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #2;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    wait_empty();
    check("rand_count", n_acc - abase, g_src.size() - gbase);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
